// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: switch conditioning, mode FSM and count prescaler.
// Drives tick/clr/hold/lap_cnt for the stopwatch datapath.
module stopwatch_ctrl #(
  parameter int DB_CYC = 4,
  parameter int PRESC  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       sw3,
  output logic       tick,
  output logic       clr,
  output logic       hold,
  output logic [1:0] state,
  output logic [3:0] lap_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } st_t;

  localparam logic [7:0]  DB_LAST = 8'(DB_CYC - 1);
  localparam logic [15:0] P_LAST  = 16'(PRESC - 1);

  logic [2:0]  raw;
  logic [2:0]  lvl;
  logic [2:0]  lvl_q;
  logic [2:0]  evt;
  st_t         st;
  st_t         nxt;
  logic        do_clr;
  logic        run;
  logic [15:0] presc;

  assign raw = {sw3, sw2, sw1};

  for (genvar i = 0; i < 3; i++) begin : g_sw
    logic       s1;
    logic       s2;
    logic       lv;
    logic [7:0] dbc;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        lv  <= 1'b0;
        dbc <= '0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
        if (s2 != lv) begin
          if (dbc == DB_LAST) begin
            lv  <= s2;
            dbc <= '0;
          end else begin
            dbc <= dbc + 8'd1;
          end
        end else begin
          dbc <= '0;
        end
      end
    end

    assign lvl[i] = lv;
  end

  // rising edge of debounced level only
  assign evt = lvl & ~lvl_q;

  always_comb begin
    nxt    = st;
    do_clr = 1'b0;
    priority case (1'b1)
      evt[2]: begin
        if (st == IDLE || st == STOP) begin
          nxt    = IDLE;
          do_clr = 1'b1;
        end
      end
      evt[0]: begin
        unique case (st)
          IDLE:    nxt = RUN;
          RUN:     nxt = STOP;
          STOP:    nxt = RUN;
          LAP:     nxt = STOP;
          default: nxt = st;
        endcase
      end
      evt[1]: begin
        if (st == RUN)      nxt = LAP;
        else if (st == LAP) nxt = RUN;
      end
      default: nxt = st;
    endcase
  end

  assign run = (st == RUN) || (st == LAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q   <= '0;
      st      <= IDLE;
      clr     <= 1'b0;
      hold    <= 1'b0;
      lap_cnt <= '0;
      presc   <= '0;
    end else begin
      lvl_q <= lvl;
      st    <= nxt;
      clr   <= do_clr;
      hold  <= (nxt == LAP);
      if (do_clr) begin
        lap_cnt <= '0;
      end else if (st == RUN && nxt == LAP && lap_cnt != 4'hf) begin
        lap_cnt <= lap_cnt + 4'd1;
      end
      if (do_clr) begin
        presc <= '0;
      end else if (run) begin
        presc <= (presc == P_LAST) ? '0 : presc + 16'd1;
      end
    end
  end

  // decoded from registered state, so never high outside RUN/LAP
  assign tick  = run && (presc == P_LAST);
  assign state = st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: reference model with per-cycle compare
// plus directed scenarios with literal expectations.
module tb_stopwatch_ctrl;

  localparam int DB = 4;
  localparam int PR = 10;

  logic       clk;
  logic       rst_n;
  logic       sw1;
  logic       sw2;
  logic       sw3;
  logic       tick;
  logic       clr;
  logic       hold;
  logic [1:0] state;
  logic [3:0] lap_cnt;

  int n_cmp;
  int n_bad;
  int clr_seen;
  int tick_seen;

  stopwatch_ctrl #(.DB_CYC(DB), .PRESC(PR)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw1(sw1),
    .sw2(sw2),
    .sw3(sw3),
    .tick(tick),
    .clr(clr),
    .hold(hold),
    .state(state),
    .lap_cnt(lap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: mode 0 idle,1 run,2 stop,3 lap; switch 0 sw1,1 sw2,2 sw3
  int tbl [4][3];
  int ms;
  int mphase;
  int mlap;
  bit mclr;
  bit mev [3];
  bit mlv [3];
  bit md1 [3];
  bit md2 [3];
  int mrun [3];

  initial begin
    tbl[0] = '{1, -1, 0};
    tbl[1] = '{2, 3, -1};
    tbl[2] = '{1, -1, 0};
    tbl[3] = '{2, 1, -1};
  end

  task automatic model_reset();
    ms = 0; mphase = 0; mlap = 0; mclr = 0;
    for (int i = 0; i < 3; i++) begin
      mev[i] = 0; mlv[i] = 0; md1[i] = 0;
      md2[i] = 0; mrun[i] = 0;
    end
  endtask

  task automatic model_step(input bit r0, input bit r1, input bit r2);
    int w;
    int ns;
    bit raw [3];
    bit sy;
    raw = '{r0, r1, r2};
    w = -1;
    if (mev[2]) w = 2;
    else if (mev[0]) w = 0;
    else if (mev[1]) w = 1;
    ns = ms;
    mclr = 0;
    if (w >= 0 && tbl[ms][w] >= 0) begin
      ns = tbl[ms][w];
      mclr = (w == 2);
    end
    if (ms == 1 || ms == 3) mphase = (mphase + 1) % PR;
    if (ms == 1 && ns == 3 && mlap < 15) mlap++;
    if (mclr) begin
      mphase = 0;
      mlap = 0;
    end
    ms = ns;
    for (int i = 0; i < 3; i++) begin
      sy = md2[i];
      md2[i] = md1[i];
      md1[i] = raw[i];
      mev[i] = 0;
      if (sy != mlv[i]) begin
        mrun[i]++;
        if (mrun[i] == DB) begin
          mlv[i] = sy;
          mrun[i] = 0;
          mev[i] = sy;
        end
      end else begin
        mrun[i] = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(sw1, sw2, sw3);
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("state", int'(state), ms);
      check("tick", int'(tick), int'((ms == 1 || ms == 3) && mphase == PR - 1));
      check("clr", int'(clr), int'(mclr));
      check("hold", int'(hold), int'(ms == 3));
      check("lap_cnt", int'(lap_cnt), mlap);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (clr) clr_seen++;
      if (tick) tick_seen++;
    end
  endtask

  task automatic press(input logic [2:0] m);
    {sw3, sw2, sw1} = m;
    step(8);
    {sw3, sw2, sw1} = 3'b000;
    step(8);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; clr_seen = 0; tick_seen = 0;
    rst_n = 1'b0;
    {sw3, sw2, sw1} = 3'b000;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check("rst_state", int'(state), 0);
    check("rst_lap", int'(lap_cnt), 0);

    // bounce shorter than debounce window
    sw1 = 1'b1;
    step(3);
    sw1 = 1'b0;
    step(12);
    check("bounce_state", int'(state), 0);

    // start latency: RUN on 7th edge after sw1 rises
    sw1 = 1'b1;
    step(6);
    check("start_pre", int'(state), 0);
    step(1);
    check("start_run", int'(state), 1);
    step(3);
    sw1 = 1'b0;
    step(10);
    check("run_after_rel", int'(state), 1);
    tick_seen = 0;
    step(30);
    check("ticks_30cyc", tick_seen, 3);

    // pause, long idle in STOP, resume
    press(3'b001);
    check("stop_state", int'(state), 2);
    tick_seen = 0;
    step(50);
    check("stop_no_tick", tick_seen, 0);
    press(3'b001);
    check("resume_state", int'(state), 1);

    // laps
    press(3'b010);
    check("lap1_state", int'(state), 3);
    check("lap1_hold", int'(hold), 1);
    press(3'b010);
    check("lap2_state", int'(state), 1);
    check("lap2_hold", int'(hold), 0);
    press(3'b010);
    check("lap3_state", int'(state), 3);
    check("lap3_cnt", int'(lap_cnt), 2);
    press(3'b010);

    // sw1+sw3 together: sw3 wins, invalid in RUN
    press(3'b101);
    check("sim_run_state", int'(state), 1);
    press(3'b001);
    check("sim_stop_pre", int'(state), 2);
    clr_seen = 0;
    press(3'b101);
    check("sim_stop_state", int'(state), 0);
    check("sim_stop_clr", clr_seen, 1);
    check("sim_stop_lap", int'(lap_cnt), 0);

    // build lap_cnt=5 in LAP, then async reset mid-cycle
    press(3'b001);
    for (int k = 0; k < 9; k++) press(3'b010);
    check("lap5_state", int'(state), 3);
    check("lap5_cnt", int'(lap_cnt), 5);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("arst_state", int'(state), 0);
    check("arst_tick", int'(tick), 0);
    check("arst_clr", int'(clr), 0);
    check("arst_hold", int'(hold), 0);
    check("arst_lap", int'(lap_cnt), 0);
    #1 rst_n = 1'b1;
    step(3);
    check("post_arst_state", int'(state), 0);

    // switch held through reset still yields an event
    sw1 = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(12);
    check("held_sw_state", int'(state), 1);
    sw1 = 1'b0;
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DB_CYC, default 4, meaning the consecutive stable cycles required to accept a switch level change (range 2..255).
REQ-002 SHALL have parameter PRESC, default 10, meaning clk cycles per count tick (range 2..65535).
REQ-003 SHALL have ports: clk  input  1  single system clock, rising-edge.
REQ-004 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports: sw1  input  1  raw start/stop switch, asynchronous.
REQ-006 SHALL have ports: sw2  input  1  raw lap switch, asynchronous.
REQ-007 SHALL have ports: sw3  input  1  raw clear switch, asynchronous.
REQ-008 SHALL have ports: tick  output  1  one-cycle count-enable pulse to the stopwatch datapath.
REQ-009 SHALL have ports: clr  output  1  one-cycle counter-clear pulse.
REQ-010 SHALL have ports: hold  output  1  display-freeze level.
REQ-011 SHALL have ports: state  output  2  current FSM state encoding.
REQ-012 SHALL have ports: lap_cnt  output  4  number of lap captures since last clear.

Function
REQ-013 SHALL pass each sw through a 2-flop synchronizer before any other use.
REQ-014 SHALL keep a per-switch debounced level; it SHALL toggle only after the synchronized input differs from it for DB_CYC consecutive cycles; any agreeing cycle restarts that count at 0.
REQ-015 SHALL generate a one-cycle event per switch on each 0->1 transition of its debounced level; 1->0 transitions produce no event.
REQ-016 SHALL, when several events occur in one cycle, consider only the highest priority (sw3 > sw1 > sw2); if that event is invalid in the current state, all events of that cycle are dropped.
REQ-017 SHALL implement states IDLE=00, RUN=01, STOP=10, LAP=11; state register updates on the edge following the event cycle.
REQ-018 IDLE: sw1 -> RUN; sw3 -> stay IDLE, issue clr; sw2 ignored.
REQ-019 RUN: sw1 -> STOP; sw2 -> LAP; sw3 ignored.
REQ-020 LAP: sw2 -> RUN; sw1 -> STOP; sw3 ignored.
REQ-021 STOP: sw1 -> RUN; sw3 -> IDLE, issue clr; sw2 ignored.
REQ-022 hold SHALL be 1 exactly while state==LAP (registered with state).
REQ-023 clr SHALL be asserted for exactly one cycle, coincident with the cycle in which the transition triggered by sw3 is registered.
REQ-024 Prescaler SHALL count 0..PRESC-1 only while state is RUN or LAP; at PRESC-1 it SHALL assert tick for that cycle and wrap to 0.
REQ-025 Prescaler SHALL hold its value in STOP (resume preserves phase) and SHALL reset to 0 when clr is issued.
REQ-026 lap_cnt SHALL increment on each RUN->LAP transition, saturate at 15, and reset to 0 when clr is issued.
REQ-027 tick SHALL never be asserted in IDLE or STOP, including the cycle the state leaves RUN/LAP.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, tick=0, clr=0, hold=0, lap_cnt=0, prescaler=0, synchronizers, debounced levels and debounce counts to 0, regardless of clk.
REQ-029 rst_n deassertion SHALL take effect on the next rising clk edge; a switch held high through reset SHALL produce an event once debounced (no event suppression).
REQ-030 Reset asserted mid-RUN SHALL not emit clr; outputs simply return to reset values.

Verification (DB_CYC=4, PRESC=10)
REQ-031 Bounce: sw1 pulses high for 3 cycles then low -> no event, state stays 00.
REQ-032 Start and tick: sw1 held high from cycle 0 -> state=01 at cycle 7 (2 sync + 4 debounce + 1 register); tick every 10th cycle thereafter; state remains 01 when sw1 is released.
REQ-033 Pause/resume: stop after 4 prescaler counts, wait 50 cycles, restart -> no tick in STOP; first tick 6 cycles after state returns to 01.
REQ-034 Lap: three sw2 press/release pairs in RUN -> state sequence 01->11->01->11, hold=1 only in 11, lap_cnt=2, ticks continue uninterrupted.
REQ-035 Simultaneous: sw1 and sw3 debounced in the same cycle in RUN -> sw3 wins, invalid, dropped; state stays 01. Same in STOP -> state=00, clr one cycle, lap_cnt=0, prescaler=0.
REQ-036 Async reset: rst_n pulled low for 3 ns mid-cycle in LAP with lap_cnt=5 -> all outputs 0 and state=00 before the next clk edge; clr not asserted.
